// File: rtl/nn_layer_engine.sv
// nn_layer_engine
//   Layer-sequenced fully-connected inference engine with MAX_NEURONS
//   parallel fixed-point MAC lanes. One start pulse runs up to MAX_LAYERS
//   layers:
//   - the input vector arrives on the in_* stream;
//   - biases and weights arrive on the prm_* stream;
//   - intermediate activations live in a ping-pong buffer pair;
//   - the final layer's results leave on the out_* stream.
//
// Handshake rule (all three streams): a word moves on a rising clk edge
// only when valid and ready are both high in the cycle before that edge.
// A producer holds its word stable until it is taken. The engine holds
// out_data/out_last stable while out_valid && !out_ready.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   start                      run request, honoured only in IDLE
//   num_layers                 layers this run, sampled at start
//   num_inputs                 input vector length, sampled at start
//   layer_n                    per-layer neuron count, layer L at [L*CNT_W +: CNT_W]
//   layer_af                   per-layer activation code, layer L at [2L +: 2]
//   in_valid/in_data/in_ready  input-vector stream
//   prm_valid/prm_data/prm_ready  bias/weight stream
//   out_valid/out_data/out_ready  result stream; out_last flags the final word
//   busy                       high in every state except IDLE
//   done                       one-cycle end-of-run pulse
//   cfg_err                    one-cycle pulse with done when the config was rejected
//   dbg_state                  current FSM state encoding (debug)
module nn_layer_engine #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int MAX_NEURONS = 16,
  parameter int MAX_LAYERS  = 4,
  parameter int CNT_W       = $clog2(MAX_NEURONS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 num_layers,
  input  logic [CNT_W-1:0]           num_inputs,
  input  logic [MAX_LAYERS*CNT_W-1:0] layer_n,
  input  logic [MAX_LAYERS*2-1:0]    layer_af,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       prm_valid,
  input  logic [DATA_W-1:0]          prm_data,
  output logic                       prm_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [2:0]                 dbg_state
);

  localparam int ACC_W = 2*DATA_W + CNT_W;
  localparam int IDX_W = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
  localparam int LID_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // Saturation bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_W-1:0] SAT_MAX_A =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN_A =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SAT_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  // Hard-tanh clamps to +/-1.0 in the fixed-point format.
  localparam logic signed [DATA_W-1:0] HT_POS = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] HT_NEG = -HT_POS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_BIAS   = 3'd2,
    S_WLOAD  = 3'd3,
    S_MAC    = 3'd4,
    S_ACT    = 3'd5,
    S_OUT    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                   r_state;
  logic                     r_sel;        // buffer holding the current layer's inputs
  logic [LID_W-1:0]         r_layer;
  logic [2:0]               r_num_layers;
  logic [CNT_W-1:0]         r_in_cnt;     // inputs feeding the current layer
  logic [CNT_W-1:0]         r_in_idx;     // input index i during WLOAD/MAC
  logic [CNT_W-1:0]         r_lane_idx;   // word index within a stream burst
  logic [CNT_W-1:0]         r_layer_n  [MAX_LAYERS];
  logic [1:0]               r_layer_af [MAX_LAYERS];
  logic signed [DATA_W-1:0] r_buf [2][MAX_NEURONS];
  logic signed [ACC_W-1:0]  r_acc [MAX_NEURONS];
  logic signed [DATA_W-1:0] r_w   [MAX_NEURONS];
  logic                     r_done;
  logic                     r_cfg_err;

  logic [CNT_W-1:0]           w_n_cur;
  logic [1:0]                 w_af_cur;
  logic                       w_last_layer;
  logic                       w_lane_last;
  logic                       w_in_last;
  logic                       w_cfg_bad;
  logic signed [DATA_W-1:0]   w_x_cur;
  logic signed [2*DATA_W-1:0] w_x_ext;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [2*DATA_W-1:0] w_w_ext    [MAX_NEURONS];
  logic signed [2*DATA_W-1:0] w_prod     [MAX_NEURONS];
  logic signed [ACC_W-1:0]    w_prod_ext [MAX_NEURONS];
  logic signed [ACC_W-1:0]    w_shift    [MAX_NEURONS];
  logic signed [DATA_W-1:0]   w_sat      [MAX_NEURONS];
  logic signed [DATA_W-1:0]   w_act      [MAX_NEURONS];

  assign w_n_cur      = r_layer_n[r_layer];
  assign w_af_cur     = r_layer_af[r_layer];
  assign w_last_layer = ((32'(r_layer) + 32'd1) == 32'(r_num_layers));
  assign w_lane_last  = (r_lane_idx == (w_n_cur - C_ONE));
  assign w_in_last    = (r_in_idx == (r_in_cnt - C_ONE));
  assign w_x_cur      = r_buf[r_sel][r_in_idx[IDX_W-1:0]];
  assign w_x_ext      = {{DATA_W{w_x_cur[DATA_W-1]}}, w_x_cur};
  assign w_bias_ext   = $signed({{(ACC_W-DATA_W){prm_data[DATA_W-1]}}, prm_data}) <<< FRAC_W;

  // Reject the run up front if any count the engine would use is out of range.
  always_comb begin
    w_cfg_bad = 1'b0;
    if ((num_layers == 3'd0) || (32'(num_layers) > MAX_LAYERS))
      w_cfg_bad = 1'b1;
    if ((num_inputs == '0) || (32'(num_inputs) > MAX_NEURONS))
      w_cfg_bad = 1'b1;
    for (int l = 0; l < MAX_LAYERS; l++) begin
      if (32'(l) < 32'(num_layers)) begin
        if ((layer_n[l*CNT_W +: CNT_W] == '0) ||
            (32'(layer_n[l*CNT_W +: CNT_W]) > MAX_NEURONS))
          w_cfg_bad = 1'b1;
      end
    end
  end

  // Per-lane datapath: widened product, then shift/saturate/activate for ACT.
  always_comb begin
    for (int j = 0; j < MAX_NEURONS; j++) begin
      w_w_ext[j]    = {{DATA_W{r_w[j][DATA_W-1]}}, r_w[j]};
      w_prod[j]     = w_x_ext * w_w_ext[j];
      w_prod_ext[j] = $signed({{CNT_W{w_prod[j][2*DATA_W-1]}}, w_prod[j]});
      w_shift[j]    = r_acc[j] >>> FRAC_W;
      if (w_shift[j] > SAT_MAX_A)
        w_sat[j] = SAT_MAX_D;
      else if (w_shift[j] < SAT_MIN_A)
        w_sat[j] = SAT_MIN_D;
      else
        w_sat[j] = w_shift[j][DATA_W-1:0];
      case (w_af_cur)
        2'd1: w_act[j] = w_sat[j][DATA_W-1] ? '0 : w_sat[j];
        2'd2: begin
          if (w_sat[j] > HT_POS)
            w_act[j] = HT_POS;
          else if (w_sat[j] < HT_NEG)
            w_act[j] = HT_NEG;
          else
            w_act[j] = w_sat[j];
        end
        default: w_act[j] = w_sat[j];  // identity; code 3 is reserved
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_layer      <= '0;
      r_num_layers <= '0;
      r_in_cnt     <= '0;
      r_in_idx     <= '0;
      r_lane_idx   <= '0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      for (int l = 0; l < MAX_LAYERS; l++) begin
        r_layer_n[l]  <= '0;
        r_layer_af[l] <= '0;
      end
      for (int j = 0; j < MAX_NEURONS; j++) begin
        r_buf[0][j] <= '0;
        r_buf[1][j] <= '0;
        r_acc[j]    <= '0;
        r_w[j]      <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_done    <= 1'b1;
              r_cfg_err <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_num_layers <= num_layers;
              for (int l = 0; l < MAX_LAYERS; l++) begin
                r_layer_n[l]  <= layer_n[l*CNT_W +: CNT_W];
                r_layer_af[l] <= layer_af[2*l +: 2];
              end
              r_sel      <= 1'b0;
              r_layer    <= '0;
              r_in_cnt   <= num_inputs;
              r_in_idx   <= '0;
              r_lane_idx <= '0;
              r_state    <= S_LOAD_X;
            end
          end
        end

        S_LOAD_X: begin
          if (in_valid) begin
            r_buf[0][r_lane_idx[IDX_W-1:0]] <= in_data;
            if (r_lane_idx == (r_in_cnt - C_ONE)) begin
              r_lane_idx <= '0;
              r_state    <= S_BIAS;
            end else begin
              r_lane_idx <= r_lane_idx + C_ONE;
            end
          end
        end

        S_BIAS: begin
          if (prm_valid) begin
            r_acc[r_lane_idx[IDX_W-1:0]] <= w_bias_ext;
            if (w_lane_last) begin
              r_lane_idx <= '0;
              r_in_idx   <= '0;
              r_state    <= S_WLOAD;
            end else begin
              r_lane_idx <= r_lane_idx + C_ONE;
            end
          end
        end

        S_WLOAD: begin
          if (prm_valid) begin
            r_w[r_lane_idx[IDX_W-1:0]] <= prm_data;
            if (w_lane_last) begin
              r_lane_idx <= '0;
              r_state    <= S_MAC;
            end else begin
              r_lane_idx <= r_lane_idx + C_ONE;
            end
          end
        end

        S_MAC: begin
          // Lanes beyond this layer's width keep their accumulators untouched.
          for (int j = 0; j < MAX_NEURONS; j++) begin
            if (CNT_W'(j) < w_n_cur)
              r_acc[j] <= r_acc[j] + w_prod_ext[j];
          end
          if (w_in_last) begin
            r_state <= S_ACT;
          end else begin
            r_in_idx <= r_in_idx + C_ONE;
            r_state  <= S_WLOAD;
          end
        end

        S_ACT: begin
          for (int j = 0; j < MAX_NEURONS; j++) begin
            if (CNT_W'(j) < w_n_cur)
              r_buf[~r_sel][j] <= w_act[j];
          end
          r_sel      <= ~r_sel;
          r_lane_idx <= '0;
          if (w_last_layer) begin
            r_state <= S_OUT;
          end else begin
            // This layer's width becomes the next layer's input count.
            r_layer  <= r_layer + LID_W'(1);
            r_in_cnt <= w_n_cur;
            r_state  <= S_BIAS;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            if (w_lane_last) begin
              r_lane_idx <= '0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_lane_idx <= r_lane_idx + C_ONE;
            end
          end
        end

        S_DONE: begin
          r_done    <= 1'b0;
          r_cfg_err <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD_X);
  assign prm_ready = (r_state == S_BIAS) || (r_state == S_WLOAD);
  assign out_valid = (r_state == S_OUT);
  // Lane index and buffer are frozen during OUT until out_ready, so the word is stable.
  assign out_data  = (r_state == S_OUT) ? r_buf[r_sel][r_lane_idx[IDX_W-1:0]] : '0;
  assign out_last  = (r_state == S_OUT) && w_lane_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed testbench for nn_layer_engine (default parameters, Q8.8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nn_layer_engine;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;
  localparam int ML     = 4;
  localparam int LIMIT  = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  start;
  logic [2:0]            num_layers;
  logic [CNT_W-1:0]      num_inputs;
  logic [ML*CNT_W-1:0]   layer_n;
  logic [ML*2-1:0]       layer_af;
  logic                  in_valid, in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  prm_valid, prm_ready;
  logic [DATA_W-1:0]     prm_data;
  logic                  out_valid, out_ready, out_last;
  logic [DATA_W-1:0]     out_data;
  logic                  busy, done, cfg_err;
  logic [2:0]            dbg_state;

  nn_layer_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_layers (num_layers),
    .num_inputs (num_inputs),
    .layer_n    (layer_n),
    .layer_af   (layer_af),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .prm_valid  (prm_valid),
    .prm_data   (prm_data),
    .prm_ready  (prm_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [2:0] nl, input logic [CNT_W-1:0] ni,
                          input logic [ML*CNT_W-1:0] ln, input logic [ML*2-1:0] af);
    num_layers = nl;
    num_inputs = ni;
    layer_n    = ln;
    layer_af   = af;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic push_in(input logic [DATA_W-1:0] d);
    int cnt = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    check("in_wait", 32'(cnt < LIMIT), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // gap=1 drops prm_valid for one cycle before each word.
  task automatic push_prm(input logic [DATA_W-1:0] d, input bit gap);
    int cnt = 0;
    if (gap) begin
      prm_valid = 1'b0;
      @(negedge clk);
    end
    prm_data  = d;
    prm_valid = 1'b1;
    while (!prm_ready && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    check("prm_wait", 32'(cnt < LIMIT), 32'd1);
    @(negedge clk);
    prm_valid = 1'b0;
  endtask

  // Waits for a result word; with stall>0 holds out_ready low that many
  // cycles and requires the word to stay put.
  task automatic pop_out(input logic [DATA_W-1:0] exp_d, input logic exp_last,
                         input int stall, input string tag);
    int cnt = 0;
    out_ready = (stall == 0);
    while (!out_valid && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, 32'(out_data), 32'(exp_d));
    end
    out_ready = 1'b1;
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_last"}, 32'(out_last), 32'(exp_last));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic end_of_run(input logic exp_err, input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cfgerr"}, 32'(cfg_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Parameters of the basic 1-layer, 2-input, 2-neuron run.
  task automatic feed_basic(input bit gap);
    push_in(16'h0100);
    push_in(16'h0200);
    push_prm(16'h0080, gap);
    push_prm(16'hFF00, gap);
    push_prm(16'h0100, gap);
    push_prm(16'h0080, gap);
    push_prm(16'hFF00, gap);
    push_prm(16'h0100, gap);
  endtask

  task automatic cfg_bad(input logic [2:0] nl, input logic [CNT_W-1:0] ni,
                         input logic [ML*CNT_W-1:0] ln, input string tag);
    do_start(nl, ni, ln, '0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_prm_ready"}, 32'(prm_ready), 32'd0);
    end_of_run(1'b1, tag);
  endtask

  // Single-neuron, single-input run used for the saturation cases.
  task automatic single(input logic [DATA_W-1:0] w, input logic [1:0] af,
                        input logic [DATA_W-1:0] exp_d, input string tag);
    do_start(3'd1, 5'd1, 20'd1, {6'd0, af});
    push_in(16'h7F00);
    push_prm(16'h0000, 1'b0);
    push_prm(w, 1'b0);
    pop_out(exp_d, 1'b1, 0, tag);
    end_of_run(1'b0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; num_layers = '0; num_inputs = '0;
    layer_n = '0; layer_af = '0; in_valid = 1'b0; in_data = '0;
    prm_valid = 1'b0; prm_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfgerr", 32'(cfg_err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ready", 32'({in_ready, prm_ready}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Identity: out = [-0.5, 1.5]
    do_start(3'd1, 5'd2, 20'd2, 8'h00);
    check("id_busy", 32'(busy), 32'd1);
    check("id_in_ready", 32'(in_ready), 32'd1);
    feed_basic(1'b0);
    pop_out(16'hFF80, 1'b0, 0, "id0");
    pop_out(16'h0180, 1'b1, 0, "id1");
    end_of_run(1'b0, "id");

    // ReLU clips the negative neuron.
    do_start(3'd1, 5'd2, 20'd2, 8'h01);
    feed_basic(1'b0);
    pop_out(16'h0000, 1'b0, 0, "relu0");
    pop_out(16'h0180, 1'b1, 0, "relu1");
    end_of_run(1'b0, "relu");

    // Two layers: ReLU layer then 1-neuron sum -> 0 + 1.5
    do_start(3'd2, 5'd2, {5'd0, 5'd0, 5'd1, 5'd2}, 8'h01);
    feed_basic(1'b0);
    push_prm(16'h0000, 1'b0);
    push_prm(16'h0100, 1'b0);
    push_prm(16'h0100, 1'b0);
    pop_out(16'h0180, 1'b1, 0, "two");
    end_of_run(1'b0, "two");

    // Saturation and hard-tanh: 127.0 * (+/-4.0)
    single(16'h0400, 2'd0, 16'h7FFF, "sat_pos");
    single(16'hFC00, 2'd0, 16'h8000, "sat_neg");
    single(16'h0400, 2'd2, 16'h0100, "htanh_pos");
    single(16'hFC00, 2'd2, 16'hFF00, "htanh_neg");

    // Stalled parameters and output backpressure; same results as identity.
    do_start(3'd1, 5'd2, 20'd2, 8'h00);
    feed_basic(1'b1);
    pop_out(16'hFF80, 1'b0, 5, "stall0");
    pop_out(16'h0180, 1'b1, 2, "stall1");
    end_of_run(1'b0, "stall");

    // Rejected configurations.
    cfg_bad(3'd0, 5'd2, 20'd2, "cfg_nl0");
    cfg_bad(3'd5, 5'd2, {5'd2, 5'd2, 5'd2, 5'd2}, "cfg_nl5");
    cfg_bad(3'd1, 5'd0, 20'd2, "cfg_ni0");
    cfg_bad(3'd2, 5'd2, {5'd0, 5'd0, 5'd17, 5'd2}, "cfg_ln17");

    // Reset in the middle of the first MAC cycle.
    do_start(3'd1, 5'd2, 20'd2, 8'h00);
    push_in(16'h0100);
    push_in(16'h0200);
    push_prm(16'h0080, 1'b0);
    push_prm(16'hFF00, 1'b0);
    push_prm(16'h0100, 1'b0);
    push_prm(16'h0080, 1'b0);
    check("mid_state_mac", 32'(dbg_state), 32'd4);
    reset = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    check("mid_outs", 32'({out_valid, out_last, done, cfg_err, in_ready, prm_ready}), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_no_done", 32'(done), 32'd0);

    do_start(3'd1, 5'd2, 20'd2, 8'h00);
    feed_basic(1'b0);
    pop_out(16'hFF80, 1'b0, 0, "rerun0");
    pop_out(16'h0180, 1'b1, 0, "rerun1");
    end_of_run(1'b0, "rerun");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
